key_debounce_multi: RTL and testbench

//   Parametrised N-channel push-button debouncer with event detection.

---
 rtl/key_debounce_multi.sv | 179 +++++++++++++++++
 tb/tb_key_debounce_multi.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/key_debounce_multi.sv
// key_debounce_multi: N-channel push-button debouncer with press/release,
// long-press and auto-repeat strobes. Each channel is synchronised, filtered
// by consecutive-sample counting and tracked by a small hold FSM.
// All outputs are registered.
module key_debounce_multi #(
  parameter int NUM_KEYS     = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int LONG_CYC     = 100000000,
  parameter int REPEAT_CYC   = 20000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat
);

  localparam int DW   = $clog2(DEBOUNCE_CYC + 1);
  localparam int HMAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [DW-1:0] DCNT_ZERO = DW'(0);
  localparam logic [DW-1:0] DCNT_ONE  = DW'(1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYC - 1);

  localparam logic [HW-1:0] HCNT_ZERO = HW'(0);
  localparam logic [HW-1:0] HCNT_ONE  = HW'(1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYC - 1);
  // Repeat terminal count is only meaningful when repeat is enabled.
  localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_CYC > 0) ? (REPEAT_CYC - 1) : 0);
  localparam logic          REPEAT_EN = (REPEAT_CYC > 0) ? 1'b1 : 1'b0;

  // Pin level that means "not pressed"; also the sample polarity flip.
  localparam logic                POL       = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [NUM_KEYS-1:0] REL_LEVEL = {NUM_KEYS{POL}};
  localparam logic [NUM_KEYS-1:0] KEYS_ZERO = {NUM_KEYS{1'b0}};

  // Hold FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HELD = 2'd1;
  localparam logic [1:0] ST_LONG = 2'd2;

  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] sync2_q, sync2_d;
  logic [NUM_KEYS-1:0] key_state_q, key_state_d;
  logic [NUM_KEYS-1:0] key_press_q, key_press_d;
  logic [NUM_KEYS-1:0] key_release_q, key_release_d;
  logic [NUM_KEYS-1:0] key_long_q, key_long_d;
  logic [NUM_KEYS-1:0] key_repeat_q, key_repeat_d;
  logic [DW-1:0]       dcnt_q   [NUM_KEYS];
  logic [DW-1:0]       dcnt_d   [NUM_KEYS];
  logic [HW-1:0]       hcnt_q   [NUM_KEYS];
  logic [HW-1:0]       hcnt_d   [NUM_KEYS];
  logic [1:0]          hstate_q [NUM_KEYS];
  logic [1:0]          hstate_d [NUM_KEYS];

  // Combinational per-channel helpers
  logic [NUM_KEYS-1:0] sample_s;
  logic [NUM_KEYS-1:0] press_ev_s;
  logic [NUM_KEYS-1:0] release_ev_s;

  // Next-state logic: synchroniser, debounce counter, event detect, hold FSM.
  always_comb begin
    sync1_d       = key_in;
    sync2_d       = sync1_q;
    key_state_d   = key_state_q;
    key_press_d   = KEYS_ZERO;
    key_release_d = KEYS_ZERO;
    key_long_d    = KEYS_ZERO;
    key_repeat_d  = KEYS_ZERO;
    sample_s      = sync2_q ^ REL_LEVEL;
    press_ev_s    = KEYS_ZERO;
    release_ev_s  = KEYS_ZERO;

    for (int i = 0; i < NUM_KEYS; i++) begin
      dcnt_d[i]   = dcnt_q[i];
      hcnt_d[i]   = hcnt_q[i];
      hstate_d[i] = hstate_q[i];

      // Debounce: any agreeing sample restarts the run.
      if (sample_s[i] == key_state_q[i]) begin
        dcnt_d[i] = DCNT_ZERO;
      end else if (dcnt_q[i] == DCNT_LAST) begin
        key_state_d[i]  = sample_s[i];
        dcnt_d[i]       = DCNT_ZERO;
        press_ev_s[i]   = sample_s[i];
        release_ev_s[i] = ~sample_s[i];
      end else begin
        dcnt_d[i] = dcnt_q[i] + DCNT_ONE;
      end

      key_press_d[i]   = press_ev_s[i];
      key_release_d[i] = release_ev_s[i];

      // Hold FSM is driven by the same-cycle accept so that key_long lands
      // exactly LONG_CYC cycles after key_press. Release wins over any strobe.
      if (release_ev_s[i]) begin
        hstate_d[i] = ST_IDLE;
        hcnt_d[i]   = HCNT_ZERO;
      end else begin
        case (hstate_q[i])
          ST_IDLE: begin
            if (press_ev_s[i]) begin
              hstate_d[i] = ST_HELD;
              hcnt_d[i]   = HCNT_ZERO;
            end else begin
              hcnt_d[i]   = HCNT_ZERO;
            end
          end
          ST_HELD: begin
            if (hcnt_q[i] == LONG_LAST) begin
              key_long_d[i] = 1'b1;
              hstate_d[i]   = ST_LONG;
              hcnt_d[i]     = HCNT_ZERO;
            end else begin
              hcnt_d[i]     = hcnt_q[i] + HCNT_ONE;
            end
          end
          ST_LONG: begin
            if (!REPEAT_EN) begin
              hcnt_d[i] = HCNT_ZERO;
            end else if (hcnt_q[i] == REP_LAST) begin
              key_repeat_d[i] = 1'b1;
              hcnt_d[i]       = HCNT_ZERO;
            end else begin
              hcnt_d[i]       = hcnt_q[i] + HCNT_ONE;
            end
          end
          default: begin
            hstate_d[i] = ST_IDLE;
            hcnt_d[i]   = HCNT_ZERO;
          end
        endcase
      end
    end
  end

  // State registers; reset parks every channel as released and idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= REL_LEVEL;
      sync2_q       <= REL_LEVEL;
      key_state_q   <= KEYS_ZERO;
      key_press_q   <= KEYS_ZERO;
      key_release_q <= KEYS_ZERO;
      key_long_q    <= KEYS_ZERO;
      key_repeat_q  <= KEYS_ZERO;
      for (int i = 0; i < NUM_KEYS; i++) begin
        dcnt_q[i]   <= DCNT_ZERO;
        hcnt_q[i]   <= HCNT_ZERO;
        hstate_q[i] <= ST_IDLE;
      end
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      key_state_q   <= key_state_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      key_long_q    <= key_long_d;
      key_repeat_q  <= key_repeat_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        dcnt_q[i]   <= dcnt_d[i];
        hcnt_q[i]   <= hcnt_d[i];
        hstate_q[i] <= hstate_d[i];
      end
    end
  end

  assign key_state   = key_state_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;
  assign key_long    = key_long_q;
  assign key_repeat  = key_repeat_q;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: an active-low instance and an
// active-high instance fed inverted pins are both checked against the same
// hand-computed expectations every cycle.
module tb_key_debounce_multi;

  localparam int NK = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_in_n;

  logic [NK-1:0] a_state, a_press, a_release, a_long, a_repeat;
  logic [NK-1:0] b_state, b_press, b_release, b_long, b_repeat;
  logic [9:0]    out_a, out_b;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic          r;
    logic [NK-1:0] keys;
    int            n;
    logic [9:0]    exp;
    string         name;
  } vec_t;

  vec_t tbl [$];

  always #5 clk = ~clk;

  assign key_in_n = ~key_in;
  assign out_a = {a_state, a_press, a_release, a_long, a_repeat};
  assign out_b = {b_state, b_press, b_release, b_long, b_repeat};

  key_debounce_multi #(
    .NUM_KEYS(NK), .ACTIVE_LOW(1), .DEBOUNCE_CYC(8), .LONG_CYC(32), .REPEAT_CYC(16)
  ) dut_a (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_state(a_state), .key_press(a_press), .key_release(a_release),
    .key_long(a_long), .key_repeat(a_repeat)
  );

  key_debounce_multi #(
    .NUM_KEYS(NK), .ACTIVE_LOW(0), .DEBOUNCE_CYC(8), .LONG_CYC(32), .REPEAT_CYC(16)
  ) dut_b (
    .clk(clk), .rst(rst), .key_in(key_in_n),
    .key_state(b_state), .key_press(b_press), .key_release(b_release),
    .key_long(b_long), .key_repeat(b_repeat)
  );

  // Pack expected outputs {state, press, release, long, repeat}.
  function automatic logic [9:0] o(input logic [1:0] st, input logic [1:0] pr,
                                   input logic [1:0] rl, input logic [1:0] lg,
                                   input logic [1:0] rp);
    return {st, pr, rl, lg, rp};
  endfunction

  task automatic add(input logic r, input logic [NK-1:0] k, input int n,
                     input logic [9:0] exp, input string name);
    vec_t v;
    v.r = r; v.keys = k; v.n = n; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask

  // Hold rst/key_in for n cycles, checking both instances after every edge.
  task automatic apply(input logic r, input logic [NK-1:0] k, input int n,
                       input logic [9:0] exp, input string name);
    for (int c = 0; c < n; c++) begin
      rst    = r;
      key_in = k;
      @(posedge clk);
      #1;
      n_vec++;
      if (out_a !== exp) begin
        n_err++;
        $display("FAIL %s[%0d] active-low: got %b want %b", name, c, out_a, exp);
      end
      n_vec++;
      if (out_b !== exp) begin
        n_err++;
        $display("FAIL %s[%0d] active-high: got %b want %b", name, c, out_b, exp);
      end
    end
  endtask

  initial begin
    logic [9:0] idle, st0, pr0, rl0, lg0, rp0;
    idle = 10'b0;
    st0  = o(2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    pr0  = o(2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    rl0  = o(2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    lg0  = o(2'b01, 2'b00, 2'b00, 2'b01, 2'b00);
    rp0  = o(2'b01, 2'b00, 2'b00, 2'b00, 2'b01);

    rst    = 1'b1;
    key_in = 2'b11;

    // Reset state, clean press/release, bounce and simultaneous channels.
    add(1'b1, 2'b11, 3, idle, "reset");
    add(1'b0, 2'b11, 3, idle, "idle");
    add(1'b0, 2'b10, 9, idle, "press_wait");
    add(1'b0, 2'b10, 1, pr0,  "press_edge");
    add(1'b0, 2'b10, 5, st0,  "press_hold");
    add(1'b0, 2'b11, 9, st0,  "release_wait");
    add(1'b0, 2'b11, 1, rl0,  "release_edge");
    add(1'b0, 2'b11, 3, idle, "released");
    add(1'b0, 2'b10, 7, idle, "bounce_low");
    add(1'b0, 2'b11, 1, idle, "bounce_glitch");
    add(1'b0, 2'b10, 9, idle, "bounce_settle");
    add(1'b0, 2'b10, 1, pr0,  "bounce_press");
    add(1'b0, 2'b11, 9, st0,  "bounce_rel_wait");
    add(1'b0, 2'b11, 1, rl0,  "bounce_release");
    add(1'b0, 2'b11, 3, idle, "bounce_idle");
    add(1'b0, 2'b00, 9, idle, "both_wait");
    add(1'b0, 2'b00, 1, o(2'b11, 2'b11, 2'b00, 2'b00, 2'b00), "both_press");
    add(1'b0, 2'b00, 2, o(2'b11, 2'b00, 2'b00, 2'b00, 2'b00), "both_hold");
    add(1'b0, 2'b11, 9, o(2'b11, 2'b00, 2'b00, 2'b00, 2'b00), "both_rel_wait");
    add(1'b0, 2'b11, 1, o(2'b00, 2'b00, 2'b11, 2'b00, 2'b00), "both_release");
    add(1'b0, 2'b11, 2, idle, "both_idle");

    foreach (tbl[j]) begin
      apply(tbl[j].r, tbl[j].keys, tbl[j].n, tbl[j].exp, tbl[j].name);
    end

    // Long press then auto-repeat every 16 cycles, then release.
    apply(1'b0, 2'b10, 9,  idle, "lr_wait");
    apply(1'b0, 2'b10, 1,  pr0,  "lr_press");
    apply(1'b0, 2'b10, 31, st0,  "lr_pre_long");
    apply(1'b0, 2'b10, 1,  lg0,  "lr_long");
    for (int r = 0; r < 4; r++) begin
      apply(1'b0, 2'b10, 15, st0, "lr_gap");
      apply(1'b0, 2'b10, 1,  rp0, "lr_repeat");
    end
    apply(1'b0, 2'b10, 4,  st0,  "lr_tail");
    apply(1'b0, 2'b11, 9,  st0,  "lr_rel_wait");
    apply(1'b0, 2'b11, 1,  rl0,  "lr_release");
    apply(1'b0, 2'b11, 10, idle, "lr_quiet");

    // Accepted release lands on the cycle a repeat would be due (+48).
    apply(1'b0, 2'b10, 9,  idle, "race_wait");
    apply(1'b0, 2'b10, 1,  pr0,  "race_press");
    apply(1'b0, 2'b10, 31, st0,  "race_pre_long");
    apply(1'b0, 2'b10, 1,  lg0,  "race_long");
    apply(1'b0, 2'b10, 6,  st0,  "race_hold");
    apply(1'b0, 2'b11, 9,  st0,  "race_rel_wait");
    apply(1'b0, 2'b11, 1,  rl0,  "race_release");
    apply(1'b0, 2'b11, 20, idle, "race_quiet");

    // Reset mid-hold with the key still down.
    apply(1'b0, 2'b10, 9,  idle, "rst_wait");
    apply(1'b0, 2'b10, 1,  pr0,  "rst_press");
    apply(1'b0, 2'b10, 19, st0,  "rst_hold");
    apply(1'b1, 2'b10, 1,  idle, "rst_pulse");
    apply(1'b0, 2'b10, 9,  idle, "rst_repress_wait");
    apply(1'b0, 2'b10, 1,  pr0,  "rst_repress");
    apply(1'b0, 2'b10, 31, st0,  "rst_no_early_long");
    apply(1'b0, 2'b10, 1,  lg0,  "rst_long");
    apply(1'b0, 2'b11, 9,  st0,  "rst_rel_wait");
    apply(1'b0, 2'b11, 1,  rl0,  "rst_release");
    apply(1'b0, 2'b11, 3,  idle, "rst_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
